fft_frame_buffer: RTL and testbench

Downstream stage of the FIR filter. It collects the filtered sample stream (`fir_valid`/`fir_d`) into 16-sample frames and presents each complete frame, fully parallel, to the FFT stage through a valid/ready handshake. Two ping-pong banks let the next frame fill while the current one waits for the FFT. Samples arriving when both banks are full are dropped and flagged.

---
 rtl/fft_frame_buffer.sv | 122 ++++++++++++
 tb/tb_fft_frame_buffer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_buffer.sv
// fft_frame_buffer: collects the FIR sample stream into FRAME_LEN-sample frames
// held in two ping-pong banks and presents each complete frame in parallel to
// the FFT over a valid/ready handshake. Samples arriving while both banks are
// full are dropped and flagged on the sticky overflow output.
// Optional feature macro: FFT_FRAME_BUF_CNT_EN builds the handshaken-frame
// counter on frame_cnt; without it frame_cnt is tied to zero.
module fft_frame_buffer #(
  parameter int unsigned FRAME_LEN = 16,
  parameter int unsigned DATA_W    = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        fir_valid,
  input  logic [DATA_W-1:0]           fir_d,
  output logic                        frame_valid,
  input  logic                        frame_ready,
  output logic [DATA_W*FRAME_LEN-1:0] frame_data,
  output logic                        overflow,
  output logic [7:0]                  frame_cnt
);

  localparam int unsigned PTR_W = $clog2(FRAME_LEN);
  localparam int unsigned FW    = DATA_W * FRAME_LEN;
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(FRAME_LEN - 1);

  typedef enum logic {FILL, STALL} wr_state_t;

  logic [DATA_W-1:0] bank [2][FRAME_LEN];
  logic [1:0]        full;
  logic [1:0]        full_nxt;
  logic              wsel;
  logic              rsel;
  logic              rsel_nxt;
  logic [PTR_W-1:0]  wptr;
  wr_state_t         state;
  logic              hs;
  logic              wr_en;
  logic              wr_last;
  logic [FW-1:0]     data_nxt;

  // Handshake, write strobes and post-edge view of the bank flags.
  // A completing write and a handshake always address different banks.
  always_comb begin
    hs       = frame_valid && frame_ready;
    wr_en    = (state == FILL) && fir_valid;
    wr_last  = wr_en && (wptr == LAST_IDX);
    rsel_nxt = rsel ^ hs;
    full_nxt = full;
    if (hs)      full_nxt[rsel] = 1'b0;
    if (wr_last) full_nxt[wsel] = 1'b1;
  end

  // Contents of the bank that will be presented after this edge, including a
  // sample being written into it on the same edge.
  always_comb begin
    data_nxt = '0;
    for (int k = 0; k < FRAME_LEN; k++) begin
      data_nxt[k*DATA_W +: DATA_W] = bank[rsel_nxt][k];
      if (wr_en && (wsel == rsel_nxt) && (wptr == PTR_W'(k)))
        data_nxt[k*DATA_W +: DATA_W] = fir_d;
    end
  end

  // Sample storage; reset clears it so frame_data starts at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < 2; b++)
        for (int k = 0; k < FRAME_LEN; k++)
          bank[b][k] <= '0;
    end else if (wr_en) begin
      bank[wsel][wptr] <= fir_d;
    end
  end

  // Write-side FSM, bank flags, read select and registered frame outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FILL;
      full        <= 2'b00;
      wsel        <= 1'b0;
      rsel        <= 1'b0;
      wptr        <= '0;
      overflow    <= 1'b0;
      frame_valid <= 1'b0;
      frame_data  <= '0;
    end else begin
      full        <= full_nxt;
      rsel        <= rsel_nxt;
      frame_valid <= full_nxt[rsel_nxt];
      frame_data  <= data_nxt;
      case (state)
        FILL: begin
          if (wr_en) begin
            wptr <= wptr + PTR_W'(1);
            if (wr_last) begin
              wptr <= '0;
              wsel <= ~wsel;
              // Stall only if the next bank stays full past this edge.
              if (full_nxt[~wsel]) state <= STALL;
            end
          end
        end
        STALL: begin
          if (fir_valid) overflow <= 1'b1;
          if (!full_nxt[wsel]) state <= FILL;
        end
        default: state <= FILL;
      endcase
    end
  end

`ifdef FFT_FRAME_BUF_CNT_EN
  // Count of handshaken frames, wrapping at 256.
  always_ff @(posedge clk) begin
    if (rst)     frame_cnt <= 8'd0;
    else if (hs) frame_cnt <= frame_cnt + 8'd1;
  end
`else
  assign frame_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_fft_frame_buffer.sv
// Self-checking bench for fft_frame_buffer: directed test-plan sequences plus
// randomized traffic, checked against a frame-level reference model.
module tb_fft_frame_buffer;

  localparam int unsigned FRAME_LEN = 16;
  localparam int unsigned DATA_W    = 16;
  localparam int unsigned FW        = FRAME_LEN * DATA_W;
`ifdef FFT_FRAME_BUF_CNT_EN
  localparam logic [7:0] CNT_AFTER_257 = 8'd1;
`else
  localparam logic [7:0] CNT_AFTER_257 = 8'd0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              fir_valid;
  logic [DATA_W-1:0] fir_d;
  logic              frame_valid;
  logic              frame_ready;
  logic [FW-1:0]     frame_data;
  logic              overflow;
  logic [7:0]        frame_cnt;

  fft_frame_buffer #(.FRAME_LEN(FRAME_LEN), .DATA_W(DATA_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .fir_valid  (fir_valid),
    .fir_d      (fir_d),
    .frame_valid(frame_valid),
    .frame_ready(frame_ready),
    .frame_data (frame_data),
    .overflow   (overflow),
    .frame_cnt  (frame_cnt)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit mon_en   = 1'b0;

  // Reference model: complete frames waiting for the FFT (oldest first),
  // the partial frame being collected, and the "both banks busy" condition.
  logic [FW-1:0] sb [$];
  int            nfull;
  logic [FW-1:0] part;
  int            pcnt;
  bit            stalled;
  logic          exp_ovf;
  logic [7:0]    exp_cnt;

  task automatic chk(input string nm, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_edge(input logic v, input logic [DATA_W-1:0] d, input logic r, input logic rs);
    bit hs;
    bit acc;
    if (rs) begin
      sb.delete();
      nfull = 0; part = '0; pcnt = 0; stalled = 1'b0;
      exp_ovf = 1'b0; exp_cnt = 8'd0;
    end else begin
      hs  = r && (nfull > 0);
      acc = v && !stalled;
      if (v && stalled) exp_ovf = 1'b1;
      if (hs) begin
        nfull--;
        stalled = 1'b0;
`ifdef FFT_FRAME_BUF_CNT_EN
        exp_cnt = 8'(exp_cnt + 8'd1);
`endif
      end
      if (acc) begin
        part[pcnt*DATA_W +: DATA_W] = d;
        pcnt++;
        if (pcnt == FRAME_LEN) begin
          sb.push_back(part);
          nfull++;
          pcnt = 0;
          part = '0;
          if (nfull == 2) stalled = 1'b1;
        end
      end
    end
  endtask

  task automatic step(input logic v, input logic [DATA_W-1:0] d, input logic r, input logic rs);
    fir_valid   = v;
    fir_d       = d;
    frame_ready = r;
    rst         = rs;
    @(posedge clk);
    model_edge(v, d, r, rs);
    #1;
  endtask

  // Per-cycle output checks and scoreboard pop on each handshake.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("frame_valid", FW'(frame_valid), FW'(nfull > 0));
      chk("overflow", FW'(overflow), FW'(exp_ovf));
      chk("frame_cnt", FW'(frame_cnt), FW'(exp_cnt));
      if (nfull > 0 && sb.size() > 0)
        chk("presented_frame", frame_data, sb[0]);
      if (frame_valid && frame_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_frame", FW'(1), FW'(0));
        end else begin
          chk("handshake_frame", frame_data, sb.pop_front());
        end
      end
    end
  end

  initial begin
    logic [FW-1:0] fd;
    int rmode;
    sb.delete();
    nfull = 0; part = '0; pcnt = 0; stalled = 1'b0; exp_ovf = 1'b0; exp_cnt = 8'd0;

    // Reset state
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1);
    mon_en = 1'b1;
    chk("rst_valid", FW'(frame_valid), FW'(0));
    chk("rst_overflow", FW'(overflow), FW'(0));
    chk("rst_cnt", FW'(frame_cnt), FW'(0));
    chk("rst_data", frame_data, FW'(0));

    // Back-to-back frame with ready held high
    for (int k = 1; k <= 16; k++) step(1'b1, 16'(k), 1'b1, 1'b0);
    fd = frame_data;
    chk("t1_valid", FW'(frame_valid), FW'(1));
    chk("t1_first", FW'(fd[15:0]), FW'(16'h0001));
    chk("t1_last", FW'(fd[255:240]), FW'(16'h0010));
    step(1'b0, '0, 1'b1, 1'b0);
    chk("t1_fall", FW'(frame_valid), FW'(0));
    chk("t1_ovf", FW'(overflow), FW'(0));

    // Both banks fill, 33rd sample dropped, then one handshake
    for (int k = 0; k < 33; k++) step(1'b1, 16'(16'h0100 + k), 1'b0, 1'b0);
    fd = frame_data;
    chk("t2_ovf", FW'(overflow), FW'(1));
    chk("t2_frame_a", FW'(fd[15:0]), FW'(16'h0100));
    step(1'b0, '0, 1'b1, 1'b0);
    fd = frame_data;
    chk("t2_valid_held", FW'(frame_valid), FW'(1));
    chk("t2_frame_b_first", FW'(fd[15:0]), FW'(16'h0110));
    chk("t2_frame_b_last", FW'(fd[255:240]), FW'(16'h011F));
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);

    // Gapped input: fir_valid toggles every cycle
    for (int k = 0; k < 32; k++) step(1'(k % 2 == 0), 16'(16'h0200 + k), 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);

    // Partial frame discarded by reset
    for (int k = 0; k < 7; k++) step(1'b1, 16'(16'h0700 + k), 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1);
    for (int k = 0; k < 16; k++) step(1'b1, 16'(16'hA000 + k), 1'b0, 1'b0);
    fd = frame_data;
    chk("t4_first", FW'(fd[15:0]), FW'(16'hA000));
    chk("t4_last", FW'(fd[255:240]), FW'(16'hA00F));
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);

    // Handshake on A coinciding with the last sample of B
    for (int k = 0; k < 16; k++) step(1'b1, 16'(16'h0A00 + k), 1'b0, 1'b0);
    for (int k = 0; k < 15; k++) step(1'b1, 16'(16'h0B00 + k), 1'b0, 1'b0);
    step(1'b1, 16'h0B0F, 1'b1, 1'b0);
    fd = frame_data;
    chk("t5_valid_held", FW'(frame_valid), FW'(1));
    chk("t5_bank_b", FW'(fd[15:0]), FW'(16'h0B00));
    step(1'b1, 16'h0C00, 1'b0, 1'b0);
    chk("t5_ovf", FW'(overflow), FW'(0));
    step(1'b0, '0, 1'b1, 1'b0);

    // Randomized traffic with varying backpressure and rare resets
    rmode = 5;
    for (int c = 0; c < 3000; c++) begin
      bit rs;
      if (c % 500 == 0) rmode = $urandom_range(0, 10);
      rs = ($urandom_range(0, 999) == 0);
      step(1'($urandom_range(0, 3) != 0), 16'($urandom), rs ? 1'b0 : 1'($urandom_range(0, 9) < rmode), rs);
    end

    // 257 handshaken frames after reset
    step(1'b0, '0, 1'b0, 1'b1);
    for (int c = 0; c < 257 * 16; c++) step(1'b1, 16'($urandom), 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("t6_cnt", FW'(frame_cnt), FW'(CNT_AFTER_257));
    chk("t6_ovf", FW'(overflow), FW'(0));

    // Drain and confirm every expected frame was delivered
    for (int c = 0; c < 40; c++) step(1'b0, '0, 1'b1, 1'b0);
    chk("sb_empty", FW'(sb.size()), FW'(0));

    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
